// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one line-wide memory port between the
//            instruction-fetch path and the data cache.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;  // 1: data side won the last grant
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ic_ready_q, ic_ready_d;
  logic              dc_ready_q, dc_ready_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_ready_d  = 1'b0;
    dc_ready_d  = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time is granted.
        if (dc_req && (!ic_req || !last_d_q)) begin
          state_d     = BUSY_D;
          last_d_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dc_we;
          mem_addr_d  = dc_addr;
          mem_wdata_d = dc_wdata;
        end else if (ic_req) begin
          state_d    = BUSY_I;
          last_d_d   = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = ic_addr;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          ic_ready_d = 1'b1;
          ic_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          dc_ready_d = 1'b1;
          if (!mem_we_q) dc_rdata_d = mem_rdata;
        end
      end
      DONE: begin
        // Dead cycle lets the owner drop its request before the next grant.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

  assign ic_ready  = ic_ready_q;
  assign dc_ready  = dc_ready_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W = 20;
  localparam int LINE_W = 128;

  logic              clock = 1'b0;
  logic              rst;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ready;
  logic [LINE_W-1:0] ic_rdata;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_ready;
  logic [LINE_W-1:0] dc_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [LINE_W-1:0] LINE_I  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_X1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [LINE_W-1:0] LINE_X2 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [LINE_W-1:0] LINE_JK = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
  localparam logic [LINE_W-1:0] LINE_5A = {16{8'h5A}};

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clock     (clock),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_ready  (ic_ready),
    .ic_rdata  (ic_rdata),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_ready  (dc_ready),
    .dc_rdata  (dc_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".mem_req"},  mem_req,  1'b0);
    check({tag, ".mem_we"},   mem_we,   1'b0);
    check({tag, ".ic_ready"}, ic_ready, 1'b0);
    check({tag, ".dc_ready"}, dc_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

    // 1: reset then idle
    tick(); tick();
    check_idle_outputs("rst");
    check("rst.mem_addr",  mem_addr,  '0);
    check("rst.mem_wdata", mem_wdata, '0);
    check("rst.ic_rdata",  ic_rdata,  '0);
    check("rst.dc_rdata",  dc_rdata,  '0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle.mem_req", mem_req, 1'b0);
    end

    // 2: instruction read, memory answers 3 cycles after grant
    ic_req = 1'b1; ic_addr = 20'h00040;
    tick();
    check("ir.mem_req",  mem_req,  1'b1);
    check("ir.mem_we",   mem_we,   1'b0);
    check("ir.mem_addr", mem_addr, 20'h00040);
    ic_addr = 20'h0BEEF;
    tick();
    check("ir.addr_stable", mem_addr, 20'h00040);
    tick();
    mem_ready = 1'b1; mem_rdata = LINE_I;
    tick();
    mem_ready = 1'b0; mem_rdata = '0; ic_req = 1'b0;
    check("ir.ic_ready", ic_ready, 1'b1);
    check("ir.ic_rdata", ic_rdata, LINE_I);
    check("ir.dc_ready", dc_ready, 1'b0);
    check("ir.mem_req_drop", mem_req, 1'b0);
    tick();
    check_idle_outputs("ir.done");
    tick();
    check("ir.no_regrant", mem_req, 1'b0);
    check("ir.rdata_hold", ic_rdata, LINE_I);

    // 3: data write-back; dc_rdata must not take the bus value
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 20'h00100; dc_wdata = LINE_A5;
    tick();
    check("wb.mem_req",   mem_req,   1'b1);
    check("wb.mem_we",    mem_we,    1'b1);
    check("wb.mem_addr",  mem_addr,  20'h00100);
    check("wb.mem_wdata", mem_wdata, LINE_A5);
    dc_wdata = LINE_5A;
    tick();
    check("wb.wdata_stable", mem_wdata, LINE_A5);
    mem_ready = 1'b1; mem_rdata = LINE_JK;
    tick();
    mem_ready = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    check("wb.dc_ready", dc_ready, 1'b1);
    check("wb.ic_ready", ic_ready, 1'b0);
    check("wb.dc_rdata", dc_rdata, '0);
    check("wb.mem_we_drop", mem_we, 1'b0);
    tick();
    check_idle_outputs("wb.done");

    // 4: simultaneous requests after reset -> D, I, D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ic_req = 1'b1; ic_addr = 20'h00200;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 20'h00300; dc_wdata = LINE_A5;
    tick();
    check("rr1.mem_addr", mem_addr, 20'h00300);
    check("rr1.mem_we",   mem_we,   1'b0);
    dc_we = 1'b1;
    mem_ready = 1'b1; mem_rdata = LINE_X1;
    tick();
    mem_ready = 1'b0;
    check("rr1.dc_ready", dc_ready, 1'b1);
    check("rr1.ic_ready", ic_ready, 1'b0);
    check("rr1.dc_rdata", dc_rdata, LINE_X1);
    tick();
    check("rr1.done_req", mem_req, 1'b0);
    check("rr1.done_rdy", dc_ready, 1'b0);
    tick();
    check("rr2.mem_req",  mem_req,  1'b1);
    check("rr2.mem_addr", mem_addr, 20'h00200);
    check("rr2.mem_we",   mem_we,   1'b0);
    mem_ready = 1'b1; mem_rdata = LINE_X2;
    tick();
    mem_ready = 1'b0;
    check("rr2.ic_ready", ic_ready, 1'b1);
    check("rr2.dc_ready", dc_ready, 1'b0);
    check("rr2.ic_rdata", ic_rdata, LINE_X2);
    check("rr2.dc_rdata", dc_rdata, LINE_X1);
    tick();
    tick();
    check("rr3.mem_addr",  mem_addr,  20'h00300);
    check("rr3.mem_we",    mem_we,    1'b1);
    check("rr3.mem_wdata", mem_wdata, LINE_A5);
    mem_ready = 1'b1; mem_rdata = LINE_JK;
    tick();
    mem_ready = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    check("rr3.dc_ready", dc_ready, 1'b1);
    check("rr3.dc_rdata", dc_rdata, LINE_X1);
    tick();
    tick();

    // 5: reset during BUSY_D; late mem_ready must be ignored
    dc_req = 1'b1; dc_addr = 20'h00400;
    tick();
    check("mr.mem_req", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; dc_req = 1'b0;
    check("mr.mem_req_rst", mem_req, 1'b0);
    mem_ready = 1'b1; mem_rdata = LINE_JK;
    tick();
    mem_ready = 1'b0;
    check_idle_outputs("mr.late");
    check("mr.dc_rdata", dc_rdata, '0);

    // 6: spurious mem_ready in IDLE, then prove the FSM still grants
    mem_ready = 1'b1; mem_rdata = LINE_JK;
    tick();
    mem_ready = 1'b0;
    check_idle_outputs("sp");
    check("sp.ic_rdata", ic_rdata, '0);
    ic_req = 1'b1; ic_addr = 20'h00055;
    tick();
    check("sp.grant", mem_req, 1'b1);
    check("sp.addr",  mem_addr, 20'h00055);
    mem_ready = 1'b1; mem_rdata = LINE_X2;
    tick();
    mem_ready = 1'b0; ic_req = 1'b0;
    check("sp.ic_ready", ic_ready, 1'b1);
    check("sp.ic_rdata2", ic_rdata, LINE_X2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
